// File: rtl/bsg_asic_clk_sequencer_if.sv
// Signal bundle between the clock sequencer and its neighbours: lock and
// restart come in, buffer enables, domain resets and status go out.
interface bsg_asic_clk_sequencer_if;
  logic       lock_i;
  logic       restart_i;
  logic       io_clk_en_o;
  logic       core_clk_en_o;
  logic       io_reset_o;
  logic       core_reset_o;
  logic       ready_o;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  modport master (
    input  lock_i,
    input  restart_i,
    output io_clk_en_o,
    output core_clk_en_o,
    output io_reset_o,
    output core_reset_o,
    output ready_o,
    output state_o,
    output lock_loss_cnt_o
  );

  modport slave (
    output lock_i,
    output restart_i,
    input  io_clk_en_o,
    input  core_clk_en_o,
    input  io_reset_o,
    input  core_reset_o,
    input  ready_o,
    input  state_o,
    input  lock_loss_cnt_o
  );
endinterface

// File: rtl/bsg_asic_clk_sequencer.sv
// Power-up / recovery sequencer for the ASIC-side clock tree.
// After PLL lock has been stable it enables the io clock, then the core
// clock, then releases io reset, then core reset, with counted gaps.
// Lock loss or a software restart tears everything down again.
// Optional feature macro: BSG_ASIC_CLK_SEQ_LOCK_SYNC_EN -- when defined,
// lock_i goes through a 2-flop synchronizer; otherwise it is used directly
// and must already be synchronous to clk_i.
module bsg_asic_clk_sequencer #(
  parameter int lock_settle_p = 64,
  parameter int clk_en_gap_p  = 16,
  parameter int reset_hold_p  = 32
) (
  input logic                       clk_i,
  input logic                       reset_n_i,
  bsg_asic_clk_sequencer_if.master  bus
);

  localparam int max_ab_p = (lock_settle_p > clk_en_gap_p) ? lock_settle_p : clk_en_gap_p;
  localparam int max_p    = (max_ab_p > reset_hold_p) ? max_ab_p : reset_hold_p;
  localparam int cnt_w_p  = $clog2(max_p) + 1;

  localparam logic [cnt_w_p-1:0] settle_last_lp = cnt_w_p'(lock_settle_p - 1);
  localparam logic [cnt_w_p-1:0] gap_last_lp    = cnt_w_p'(clk_en_gap_p - 1);
  localparam logic [cnt_w_p-1:0] hold_last_lp   = cnt_w_p'(reset_hold_p - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    IO_EN     = 3'd2,
    CORE_EN   = 3'd3,
    IO_RUN    = 3'd4,
    RUN       = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [cnt_w_p-1:0] cnt_q, cnt_d;
  logic [7:0]         loss_cnt_q, loss_cnt_d;
  logic               io_clk_en_q, io_clk_en_d;
  logic               core_clk_en_q, core_clk_en_d;
  logic               io_reset_q, io_reset_d;
  logic               core_reset_q, core_reset_d;
  logic               ready_q, ready_d;
  logic               lock_s;
  logic               abort;
  logic               count_loss;

`ifdef BSG_ASIC_CLK_SEQ_LOCK_SYNC_EN
  logic [1:0] lock_sync_q, lock_sync_d;

  // Shift the asynchronous lock into the two-stage synchronizer
  always_comb begin
    lock_sync_d = {lock_sync_q[0], bus.lock_i};
  end

  // Synchronizer flops, cleared while the sequencer is in reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) lock_sync_q <= '0;
    else            lock_sync_q <= lock_sync_d;
  end

  assign lock_s = lock_sync_q[1];
`else
  assign lock_s = bus.lock_i;
`endif

  // Next-state, gap counter and lock-loss counter; abort overrides stepping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_w_p'(1);
    loss_cnt_d = loss_cnt_q;
    abort      = (state_q != WAIT_LOCK) && (!lock_s || bus.restart_i);
    count_loss = !lock_s && (state_q != WAIT_LOCK) && (state_q != SETTLE);

    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      if (count_loss && (loss_cnt_q != 8'hff)) loss_cnt_d = loss_cnt_q + 8'd1;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_d = '0;
          if (lock_s) state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == settle_last_lp) begin
            state_d = IO_EN;
            cnt_d   = '0;
          end
        end
        IO_EN: begin
          if (cnt_q == gap_last_lp) begin
            state_d = CORE_EN;
            cnt_d   = '0;
          end
        end
        CORE_EN: begin
          if (cnt_q == hold_last_lp) begin
            state_d = IO_RUN;
            cnt_d   = '0;
          end
        end
        IO_RUN: begin
          if (cnt_q == gap_last_lp) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    io_clk_en_d   = (state_d == IO_EN) || (state_d == CORE_EN) ||
                    (state_d == IO_RUN) || (state_d == RUN);
    core_clk_en_d = (state_d == CORE_EN) || (state_d == IO_RUN) || (state_d == RUN);
    io_reset_d    = !((state_d == IO_RUN) || (state_d == RUN));
    core_reset_d  = (state_d != RUN);
    ready_d       = (state_d == RUN);
  end

  // State, counters and registered outputs; reset forces the idle picture
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      loss_cnt_q    <= '0;
      io_clk_en_q   <= 1'b0;
      core_clk_en_q <= 1'b0;
      io_reset_q    <= 1'b1;
      core_reset_q  <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      io_clk_en_q   <= io_clk_en_d;
      core_clk_en_q <= core_clk_en_d;
      io_reset_q    <= io_reset_d;
      core_reset_q  <= core_reset_d;
      ready_q       <= ready_d;
    end
  end

  assign bus.io_clk_en_o     = io_clk_en_q;
  assign bus.core_clk_en_o   = core_clk_en_q;
  assign bus.io_reset_o      = io_reset_q;
  assign bus.core_reset_o    = core_reset_q;
  assign bus.ready_o         = ready_q;
  assign bus.state_o         = state_q;
  assign bus.lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_bsg_asic_clk_sequencer.sv
// Directed testbench for bsg_asic_clk_sequencer with default parameters.
// Works with or without BSG_ASIC_CLK_SEQ_LOCK_SYNC_EN (lock latency LAT).
module tb_bsg_asic_clk_sequencer;

`ifdef BSG_ASIC_CLK_SEQ_LOCK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   exp_loss  = 0;

  always #5 clk = ~clk;

  bsg_asic_clk_sequencer_if bus ();

  bsg_asic_clk_sequencer #(
    .lock_settle_p(64),
    .clk_en_gap_p (16),
    .reset_hold_p (32)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  task automatic runCycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic restart, input logic rstn);
    bus.lock_i    = lock;
    bus.restart_i = restart;
    rst_n         = rstn;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_state"},    {5'd0, bus.state_o}, 8'd0);
    checkOutput({tag, "_io_en"},    {7'd0, bus.io_clk_en_o}, 8'd0);
    checkOutput({tag, "_core_en"},  {7'd0, bus.core_clk_en_o}, 8'd0);
    checkOutput({tag, "_io_rst"},   {7'd0, bus.io_reset_o}, 8'd1);
    checkOutput({tag, "_core_rst"}, {7'd0, bus.core_reset_o}, 8'd1);
    checkOutput({tag, "_ready"},    {7'd0, bus.ready_o}, 8'd0);
    checkOutput({tag, "_cnt"},      bus.lock_loss_cnt_o, 8'(exp_loss));
  endtask

  // first = cycles from now until edge E0+63
  task automatic doSequence(input int first, input string tag);
    runCycles(first);
    checkOutput({tag, "_io_en_pre"}, {7'd0, bus.io_clk_en_o}, 8'd0);
    checkOutput({tag, "_st_settle"}, {5'd0, bus.state_o}, 8'd1);
    runCycles(1);
    checkOutput({tag, "_io_en"}, {7'd0, bus.io_clk_en_o}, 8'd1);
    checkOutput({tag, "_st_io_en"}, {5'd0, bus.state_o}, 8'd2);
    runCycles(15);
    checkOutput({tag, "_core_en_pre"}, {7'd0, bus.core_clk_en_o}, 8'd0);
    runCycles(1);
    checkOutput({tag, "_core_en"}, {7'd0, bus.core_clk_en_o}, 8'd1);
    checkOutput({tag, "_st_core_en"}, {5'd0, bus.state_o}, 8'd3);
    runCycles(31);
    checkOutput({tag, "_io_rst_pre"}, {7'd0, bus.io_reset_o}, 8'd1);
    runCycles(1);
    checkOutput({tag, "_io_rst"}, {7'd0, bus.io_reset_o}, 8'd0);
    checkOutput({tag, "_st_io_run"}, {5'd0, bus.state_o}, 8'd4);
    checkOutput({tag, "_core_rst_hold"}, {7'd0, bus.core_reset_o}, 8'd1);
    runCycles(15);
    checkOutput({tag, "_ready_pre"}, {7'd0, bus.ready_o}, 8'd0);
    runCycles(1);
    checkOutput({tag, "_ready"}, {7'd0, bus.ready_o}, 8'd1);
    checkOutput({tag, "_core_rst"}, {7'd0, bus.core_reset_o}, 8'd0);
    checkOutput({tag, "_st_run"}, {5'd0, bus.state_o}, 8'd5);
    checkOutput({tag, "_cnt"}, bus.lock_loss_cnt_o, 8'(exp_loss));
  endtask

  initial begin
    $display("[TB] start, lock latency %0d", LAT);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(3);
    checkIdle("reset");
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(200);
    checkIdle("idle200");

    // Full power-up sequence
    applyStimulus(1'b1, 1'b0, 1'b1);
    doSequence(LAT + 64, "seq1");

    // Lock drop in RUN
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(LAT);
    checkOutput("run_drop_pre_state", {5'd0, bus.state_o}, 8'd5);
    runCycles(1);
    exp_loss = exp_loss + 1;
    checkIdle("run_drop");

    // Relock, then one-cycle drop 30 cycles into SETTLE
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(LAT + 1);
    checkOutput("settle_enter", {5'd0, bus.state_o}, 8'd1);
    runCycles(29);
    checkOutput("settle_30", {5'd0, bus.state_o}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(LAT);
    checkIdle("settle_drop");
    doSequence(64, "seq2");

    // Restart and lock loss sampled together in RUN: counted once
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(LAT);
    applyStimulus(1'b0, 1'b1, 1'b1);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    exp_loss = exp_loss + 1;
    checkIdle("restart_and_loss");

    // Restart in WAIT_LOCK has no effect
    applyStimulus(1'b0, 1'b1, 1'b1);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(1);
    checkIdle("restart_in_wait");

    // Restart alone in RUN: abort without counting, one cycle in WAIT_LOCK
    applyStimulus(1'b1, 1'b0, 1'b1);
    doSequence(LAT + 64, "seq3");
    applyStimulus(1'b1, 1'b1, 1'b1);
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkIdle("restart_only");
    runCycles(1);
    checkOutput("relock_after_restart", {5'd0, bus.state_o}, 8'd1);

    // Lock drop while in SETTLE is not counted
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(LAT + 1);
    checkIdle("settle_abort");

    // 300 lock-loss events inside IO_EN: counter saturates
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      runCycles(LAT + 66);
      applyStimulus(1'b0, 1'b0, 1'b1);
      runCycles(LAT + 1);
      exp_loss = (exp_loss >= 255) ? 255 : exp_loss + 1;
      if (i == 0) checkOutput("sat_first", bus.lock_loss_cnt_o, 8'(exp_loss));
    end
    checkOutput("sat_model", bus.lock_loss_cnt_o, 8'(exp_loss));
    checkOutput("sat_255", bus.lock_loss_cnt_o, 8'd255);
    checkOutput("sat_state", {5'd0, bus.state_o}, 8'd0);

    // Reset asserted in IO_RUN clears everything including the loss count
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(LAT + 114);
    checkOutput("io_run_before_reset", {5'd0, bus.state_o}, 8'd4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(1);
    exp_loss = 0;
    checkIdle("reset_in_io_run");
    applyStimulus(1'b1, 1'b0, 1'b1);
    doSequence(LAT + 64, "seq_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
